// File: rtl/display_source_mux_if.sv
// rtl/display_source_mux_if.sv - source-side and display-side buses of the display source mux
// master drives the per-source buses and watches the display; slave is the mux itself.
interface display_source_mux_if #(
  parameter int N_CH  = 4,
  parameter int LED_W = 10
);
  localparam int MODE_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH*LED_W-1:0] ch_leds;
  logic [N_CH*48-1:0]    ch_hex;
  logic [LED_W-1:0]      leds;
  logic [7:0]            hex0;
  logic [7:0]            hex1;
  logic [7:0]            hex2;
  logic [7:0]            hex3;
  logic [7:0]            hex4;
  logic [7:0]            hex5;
  logic [MODE_W-1:0]     mode;

  modport master (
    output ch_leds, ch_hex,
    input  leds, hex0, hex1, hex2, hex3, hex4, hex5, mode
  );

  modport slave (
    input  ch_leds, ch_hex,
    output leds, hex0, hex1, hex2, hex3, hex4, hex5, mode
  );
endinterface

// File: rtl/display_source_mux.sv
// rtl/display_source_mux.sv - KEY-cycled registered selector for LEDR/HEX0..HEX5
// Source changes blank the display for BLANK_CYCLES clocks while HEX5 shows the new index.
module display_source_mux #(
  parameter int N_CH         = 4,
  parameter int LED_W        = 10,
  parameter int DB_CYCLES    = 500000,
  parameter int BLANK_CYCLES = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_next_n,
  input  logic key_prev_n,
  display_source_mux_if.slave bus
);
  localparam int MODE_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int TMR_W  = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(N_CH - 1);

  typedef enum logic {SHOW, BLANK} state_t;

  // Bit 0 is the next key, bit 1 the previous key.
  logic [1:0]       w_keys;
  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [1:0]       r_stable;
  logic [CNT_W-1:0] r_cnt [2];
  logic [1:0]       w_press;
  logic             w_valid;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TMR_W-1:0] r_timer;
  logic [TMR_W-1:0] w_timer_nxt;
  logic [MODE_W-1:0] r_mode;
  logic [MODE_W-1:0] w_mode_nxt;
  logic [LED_W-1:0] r_leds;
  logic [LED_W-1:0] w_leds_nxt;
  logic [47:0]      r_hex;
  logic [47:0]      w_hex_nxt;

  function automatic logic [7:0] seg7(input logic [MODE_W-1:0] d);
    case (int'(d))
      0: seg7 = 8'hC0;
      1: seg7 = 8'hF9;
      2: seg7 = 8'hA4;
      3: seg7 = 8'hB0;
      4: seg7 = 8'h99;
      5: seg7 = 8'h92;
      6: seg7 = 8'h82;
      7: seg7 = 8'hF8;
      8: seg7 = 8'h80;
      9: seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  assign w_keys = {key_prev_n, key_next_n};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1  <= 2'b11;
      r_sync2  <= 2'b11;
      r_stable <= 2'b11;
      for (int k = 0; k < 2; k++) r_cnt[k] <= '0;
    end else begin
      r_sync1 <= w_keys;
      r_sync2 <= r_sync1;
      for (int k = 0; k < 2; k++) begin
        if (r_sync2[k] == r_stable[k]) begin
          r_cnt[k] <= '0;
        end else if (r_cnt[k] == DB_LAST) begin
          r_stable[k] <= r_sync2[k];
          r_cnt[k]    <= '0;
        end else begin
          r_cnt[k] <= r_cnt[k] + 1'b1;
        end
      end
    end
  end

  // A press fires in the same cycle the debounced level falls.
  always_comb begin
    w_press = 2'b00;
    for (int k = 0; k < 2; k++)
      w_press[k] = (r_sync2[k] != r_stable[k]) && (r_cnt[k] == DB_LAST) && !r_sync2[k];
  end

  assign w_valid = w_press[0] ^ w_press[1];

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_mode_nxt  = r_mode;
    w_leds_nxt  = '0;
    w_hex_nxt   = '1;
    if (w_valid) begin
      if (w_press[0]) w_mode_nxt = (r_mode == MODE_LAST) ? '0 : r_mode + 1'b1;
      else            w_mode_nxt = (r_mode == '0) ? MODE_LAST : r_mode - 1'b1;
    end
    case (r_state)
      SHOW: begin
        for (int c = 0; c < N_CH; c++) begin
          if (r_mode == MODE_W'(c)) begin
            w_leds_nxt = bus.ch_leds[c*LED_W +: LED_W];
            w_hex_nxt  = bus.ch_hex[c*48 +: 48];
          end
        end
        if (w_valid && (BLANK_CYCLES > 0)) begin
          w_state_nxt = BLANK;
          w_timer_nxt = TMR_LAST;
        end
      end
      BLANK: begin
        w_hex_nxt[47:40] = seg7(r_mode);
        if (w_valid)              w_timer_nxt = TMR_LAST;
        else if (r_timer == '0)   w_state_nxt = SHOW;
        else                      w_timer_nxt = r_timer - 1'b1;
      end
      default: w_state_nxt = SHOW;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SHOW;
      r_timer <= '0;
      r_mode  <= '0;
      r_leds  <= '0;
      r_hex   <= '1;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_mode  <= w_mode_nxt;
      r_leds  <= w_leds_nxt;
      r_hex   <= w_hex_nxt;
    end
  end

  assign bus.leds = r_leds;
  assign bus.hex0 = r_hex[7:0];
  assign bus.hex1 = r_hex[15:8];
  assign bus.hex2 = r_hex[23:16];
  assign bus.hex3 = r_hex[31:24];
  assign bus.hex4 = r_hex[39:32];
  assign bus.hex5 = r_hex[47:40];
  assign bus.mode = r_mode;
endmodule

// File: tb/tb_display_source_mux.sv
// tb/tb_display_source_mux.sv - directed bench for display_source_mux
// N_CH=3, DB_CYCLES=4, BLANK_CYCLES=8; outputs sampled 1 ns after each rising edge.
module tb_display_source_mux;
  localparam int N_CH  = 3;
  localparam int LED_W = 10;
  localparam int DB    = 4;
  localparam int BL    = 8;

  logic clk = 1'b0;
  logic reset;
  logic key_next_n;
  logic key_prev_n;
  logic [LED_W-1:0] leds_tab [N_CH];
  int n_checks = 0;
  int n_fail   = 0;

  display_source_mux_if #(.N_CH(N_CH), .LED_W(LED_W)) bus();

  display_source_mux #(
    .N_CH(N_CH), .LED_W(LED_W), .DB_CYCLES(DB), .BLANK_CYCLES(BL)
  ) dut (
    .clk(clk), .reset(reset), .key_next_n(key_next_n), .key_prev_n(key_prev_n), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] hex_val(input int c, input int i);
    return 8'((c << 4) | i);
  endfunction

  always_comb begin
    bus.ch_leds = '0;
    bus.ch_hex  = '0;
    for (int c = 0; c < N_CH; c++) begin
      bus.ch_leds[c*LED_W +: LED_W] = leds_tab[c];
      for (int i = 0; i < 6; i++) bus.ch_hex[c*48 + i*8 +: 8] = hex_val(c, i);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_src(input string tag, input int c);
    logic [7:0] h [6];
    h = '{bus.hex0, bus.hex1, bus.hex2, bus.hex3, bus.hex4, bus.hex5};
    check({tag, ".leds"}, 32'(bus.leds), 32'(leds_tab[c]));
    for (int i = 0; i < 6; i++) check($sformatf("%s.hex%0d", tag, i), 32'(h[i]), 32'(hex_val(c, i)));
  endtask

  task automatic check_dark(input string tag, input logic [7:0] digit);
    logic [7:0] h [6];
    h = '{bus.hex0, bus.hex1, bus.hex2, bus.hex3, bus.hex4, bus.hex5};
    check({tag, ".leds"}, 32'(bus.leds), 32'h0);
    for (int i = 0; i < 5; i++) check($sformatf("%s.hex%0d", tag, i), 32'(h[i]), 32'hFF);
    check({tag, ".hex5"}, 32'(h[5]), 32'(digit));
  endtask

  task automatic expect_blank(input string tag, input logic [7:0] digit, input int c);
    for (int t = 0; t < BL; t++) begin
      tick();
      check_dark($sformatf("%s.blank%0d", tag, t), digit);
    end
    tick();
    check_src({tag, ".src"}, c);
    check({tag, ".mode"}, 32'(bus.mode), 32'(c));
  endtask

  // Drives a key low and waits for the mode to move; debounce puts that 6 edges after the drive.
  task automatic press(input string tag, input bit is_next, input int exp_mode, input bit hold);
    logic [1:0] start;
    int n;
    start = bus.mode;
    if (is_next) key_next_n = 1'b0;
    else         key_prev_n = 1'b0;
    n = 0;
    while (bus.mode == start && n < 20) begin
      tick();
      n++;
    end
    check({tag, ".latency"}, 32'(n), 32'd6);
    check({tag, ".mode"}, 32'(bus.mode), 32'(exp_mode));
    if (!hold) begin
      key_next_n = 1'b1;
      key_prev_n = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    leds_tab[0] = 10'h155;
    leds_tab[1] = 10'h2AA;
    leds_tab[2] = 10'h0F0;
    reset = 1'b1;
    key_next_n = 1'b1;
    key_prev_n = 1'b1;
    tick();
    tick();
    check("rst.mode", 32'(bus.mode), 32'd0);
    check_dark("rst", 8'hFF);
    reset = 1'b0;
    tick();
    check_src("rst.ch0", 0);

    leds_tab[0] = 10'h3C3;
    check("in.before", 32'(bus.leds), 32'h155);
    tick();
    check("in.after", 32'(bus.leds), 32'h3C3);
    leds_tab[0] = 10'h155;
    tick();

    press("held", 1'b1, 1, 1'b1);
    expect_blank("held", 8'hF9, 1);
    for (int t = 0; t < 5; t++) begin
      tick();
      check($sformatf("held.stay%0d", t), 32'(bus.mode), 32'd1);
    end
    check_src("held.end", 1);
    key_next_n = 1'b1;
    repeat (10) tick();
    check("held.release", 32'(bus.mode), 32'd1);

    press("prev1", 1'b0, 0, 1'b0);
    expect_blank("prev1", 8'hC0, 0);
    press("wrap_prev", 1'b0, 2, 1'b0);
    expect_blank("wrap_prev", 8'hA4, 2);
    press("wrap_next", 1'b1, 0, 1'b0);
    expect_blank("wrap_next", 8'hC0, 0);

    for (int b = 0; b < 5; b++) begin
      key_next_n = 1'b0;
      tick();
      tick();
      key_next_n = 1'b1;
      tick();
      tick();
    end
    repeat (10) tick();
    check("bounce.mode", 32'(bus.mode), 32'd0);
    check_src("bounce", 0);

    // prev fires at edge E, next (driven 3 clocks later) at E+3, inside the blank.
    key_prev_n = 1'b0;
    repeat (3) begin
      tick();
      check("pdb.wait", 32'(bus.mode), 32'd0);
    end
    key_next_n = 1'b0;
    repeat (2) tick();
    check("pdb.pre", 32'(bus.mode), 32'd0);
    tick();
    check("pdb.first", 32'(bus.mode), 32'd2);
    key_prev_n = 1'b1;
    tick();
    check_dark("pdb.b1", 8'hA4);
    tick();
    check_dark("pdb.b2", 8'hA4);
    tick();
    check("pdb.second", 32'(bus.mode), 32'd0);
    check_dark("pdb.b3", 8'hA4);
    key_next_n = 1'b1;
    expect_blank("pdb", 8'hC0, 0);

    key_next_n = 1'b0;
    key_prev_n = 1'b0;
    repeat (10) tick();
    check("both.mode", 32'(bus.mode), 32'd0);
    check_src("both", 0);
    key_next_n = 1'b1;
    key_prev_n = 1'b1;
    repeat (10) tick();
    check("both.release", 32'(bus.mode), 32'd0);

    press("rstmid", 1'b1, 1, 1'b0);
    repeat (3) tick();
    check_dark("rstmid.blank", 8'hF9);
    reset = 1'b1;
    tick();
    check("rstmid.mode", 32'(bus.mode), 32'd0);
    check_dark("rstmid.dark", 8'hFF);
    reset = 1'b0;
    tick();
    check_src("rstmid.ch0", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
